// File: rtl/fetch_unit.sv
// Instruction-fetch / PC-sequencing stage: holds PC, fetches one word per instruction
// over a req/ack handshake and computes the next PC when the instruction retires.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  PCSrc,
    input  logic [15:0] Imm,
    input  logic [25:0] Target,
    input  logic [31:0] RsData,
    input  logic        Retire,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic [31:0] IMemRdata,
    input  logic        IMemAck,
    output logic [31:0] Instr,
    output logic [5:0]  Opcode,
    output logic [5:0]  Funct,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        Fault
);

    // The counter only has to reach MAX_WAIT-1, so clog2(MAX_WAIT) bits are enough.
    localparam int WCW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t          state_reg;
    logic [31:0]     pc_reg;
    logic [31:0]     instr_reg;
    logic [WCW-1:0]  waitcnt_reg;

    logic [31:0]     pc_plus4;
    logic [31:0]     branch_off;
    logic [31:0]     pc_next;

    assign pc_plus4   = pc_reg + 32'd4;
    assign branch_off = {{14{Imm[15]}}, Imm, 2'b00};

    always_comb begin
        pc_next = pc_plus4;
        case (PCSrc)
            2'd0:    pc_next = pc_plus4;
            2'd1:    pc_next = pc_plus4 + branch_off;
            2'd2:    pc_next = RsData;
            default: pc_next = {pc_plus4[31:28], Target, 2'b00};
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg   <= IDLE;
            pc_reg      <= RESET_PC;
            instr_reg   <= 32'h0;
            waitcnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: state_reg <= FETCH;
                FETCH: begin
                    // An ack on the last allowed cycle still wins over the timeout.
                    if (IMemAck) begin
                        instr_reg   <= IMemRdata;
                        waitcnt_reg <= '0;
                        state_reg   <= HOLD;
                    end else if (waitcnt_reg == WAIT_LAST) begin
                        state_reg <= FAULT;
                    end else begin
                        waitcnt_reg <= waitcnt_reg + 1'b1;
                    end
                end
                HOLD: begin
                    if (Retire) begin
                        pc_reg    <= pc_next;
                        state_reg <= (pc_next[1:0] != 2'b00) ? FAULT : FETCH;
                    end
                end
                default: state_reg <= FAULT;
            endcase
        end
    end

    assign IMemReq    = (state_reg == FETCH);
    assign InstrValid = (state_reg == HOLD);
    assign Fault      = (state_reg == FAULT);
    assign IMemAddr   = pc_reg;
    assign PC         = pc_reg;
    assign PCPlus4    = pc_plus4;
    assign Instr      = instr_reg;
    assign Opcode     = instr_reg[31:26];
    assign Funct      = instr_reg[5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequencing for every PCSrc, handshake timing,
// misalignment and timeout faults. The DUT runs with MAX_WAIT=4 to keep timeouts short.
module tb_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [1:0]  PCSrc;
    logic [15:0] Imm;
    logic [25:0] Target;
    logic [31:0] RsData;
    logic        Retire;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic [31:0] IMemRdata;
    logic        IMemAck;
    logic [31:0] Instr;
    logic [5:0]  Opcode;
    logic [5:0]  Funct;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        Fault;

    int total_cnt = 0;
    int bad_cnt   = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .MAX_WAIT(4)) dut (
        .Clk(Clk), .Reset(Reset), .PCSrc(PCSrc), .Imm(Imm), .Target(Target),
        .RsData(RsData), .Retire(Retire), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
        .IMemRdata(IMemRdata), .IMemAck(IMemAck), .Instr(Instr), .Opcode(Opcode),
        .Funct(Funct), .InstrValid(InstrValid), .PC(PC), .PCPlus4(PCPlus4), .Fault(Fault)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Advance one clock and land 1 time unit after the edge, where outputs are sampled.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // DUT is in FETCH: answer immediately, land in HOLD.
    task automatic ack_now(input logic [31:0] word);
        IMemAck   = 1'b1;
        IMemRdata = word;
        tick();
        IMemAck   = 1'b0;
    endtask

    // DUT is in HOLD: retire with the given next-PC selection.
    task automatic retire(input logic [1:0] src, input logic [15:0] imm,
                          input logic [25:0] tgt, input logic [31:0] rs);
        PCSrc  = src;
        Imm    = imm;
        Target = tgt;
        RsData = rs;
        Retire = 1'b1;
        tick();
        Retire = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; PCSrc = 2'd0; Imm = 16'h0; Target = 26'h0; RsData = 32'h0;
        Retire = 1'b0; IMemRdata = 32'h0; IMemAck = 1'b0;

        // T1: reset state, bubble, ack in the first FETCH cycle
        tick();
        chk("rst_req",   {31'b0, IMemReq},    32'h0);
        chk("rst_valid", {31'b0, InstrValid}, 32'h0);
        chk("rst_fault", {31'b0, Fault},      32'h0);
        chk("rst_pc",    PC,                  32'h0);
        chk("rst_instr", Instr,               32'h0);
        Reset = 1'b0;
        tick();
        chk("t1_req",  {31'b0, IMemReq}, 32'h1);
        chk("t1_addr", IMemAddr,         32'h0);
        ack_now(32'h2008_0005);
        chk("t1_valid",  {31'b0, InstrValid}, 32'h1);
        chk("t1_opcode", {26'b0, Opcode},     32'h08);
        chk("t1_funct",  {26'b0, Funct},      32'h05);
        chk("t1_pc",     PC,                  32'h0);
        chk("t1_pc4",    PCPlus4,             32'h4);
        chk("t1_reqlo",  {31'b0, IMemReq},    32'h0);

        // Retire while stalled in HOLD is the only way out; Retire=0 holds
        tick();
        chk("hold_stay", {31'b0, InstrValid}, 32'h1);

        // T2: sequential
        retire(2'd0, 16'h0, 26'h0, 32'h0);
        chk("t2_req",   {31'b0, IMemReq},    32'h1);
        chk("t2_addr",  IMemAddr,            32'h4);
        chk("t2_valid", {31'b0, InstrValid}, 32'h0);
        // Retire during FETCH must be ignored
        Retire = 1'b1; PCSrc = 2'd2; RsData = 32'h0000_0800;
        tick();
        Retire = 1'b0;
        chk("t2_retire_ign", IMemAddr, 32'h4);
        ack_now(32'h0);

        // T3: branches from PC=0x10
        retire(2'd2, 16'h0, 26'h0, 32'h10);
        chk("t3_jr_addr", IMemAddr, 32'h10);
        ack_now(32'h1000_FFFF);
        retire(2'd1, 16'hFFFF, 26'h0, 32'h0);
        chk("t3_br_back", IMemAddr, 32'h10);
        ack_now(32'h1000_0003);
        retire(2'd1, 16'h0003, 26'h0, 32'h0);
        chk("t3_br_fwd", IMemAddr, 32'h20);
        ack_now(32'h0);

        // T4: jump from PC=0x0040_0008
        retire(2'd2, 16'h0, 26'h0, 32'h0040_0008);
        ack_now(32'h0810_0003);
        retire(2'd3, 16'h0, 26'h010_0003, 32'h0);
        chk("t4_j_addr", IMemAddr, 32'h0040_000C);
        ack_now(32'h0);

        // T6b: PC wraps past 2^32
        retire(2'd2, 16'h0, 26'h0, 32'hFFFF_FFFC);
        chk("t6_pcmax", IMemAddr, 32'hFFFF_FFFC);
        ack_now(32'h0);
        chk("t6_pc4wrap", PCPlus4, 32'h0);
        retire(2'd0, 16'h0, 26'h0, 32'h0);
        chk("t6_wrap_addr", IMemAddr, 32'h0);

        // T6: ack on the 4th (last) FETCH cycle takes priority over timeout
        tick(); tick(); tick();
        chk("t6_late_req", {31'b0, IMemReq}, 32'h1);
        ack_now(32'hABCD_1234);
        chk("t6_late_valid", {31'b0, InstrValid}, 32'h1);
        chk("t6_late_fault", {31'b0, Fault},      32'h0);
        chk("t6_late_instr", Instr,               32'hABCD_1234);

        // T6: no ack -> fault after 4 FETCH cycles
        retire(2'd0, 16'h0, 26'h0, 32'h0);
        tick(); tick(); tick();
        chk("t6_to_prefault", {31'b0, Fault}, 32'h0);
        tick();
        chk("t6_to_fault", {31'b0, Fault},   32'h1);
        chk("t6_to_req",   {31'b0, IMemReq}, 32'h0);

        // Reset mid-fetch abandons the request
        Reset = 1'b1; tick(); Reset = 1'b0;
        tick();
        chk("midrst_req", {31'b0, IMemReq}, 32'h1);
        Reset = 1'b1; tick();
        chk("midrst_drop", {31'b0, IMemReq}, 32'h0);
        Reset = 1'b0; tick();

        // T5: misaligned jr -> sticky fault, acks and retires ignored
        ack_now(32'h0000_0008);
        retire(2'd2, 16'h0, 26'h0, 32'h0000_0102);
        chk("t5_fault", {31'b0, Fault}, 32'h1);
        begin
            logic saw_req = 1'b0;
            logic lost_flt = 1'b0;
            IMemAck = 1'b1; Retire = 1'b1; PCSrc = 2'd0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (IMemReq) saw_req = 1'b1;
                if (!Fault) lost_flt = 1'b1;
            end
            IMemAck = 1'b0; Retire = 1'b0;
            chk("t5_no_req",     {31'b0, saw_req},  32'h0);
            chk("t5_sticky",     {31'b0, lost_flt}, 32'h0);
            chk("t5_pc_frozen",  PC,                32'h0000_0102);
            chk("t5_ins_frozen", Instr,             32'h0000_0008);
        end
        Reset = 1'b1; tick();
        chk("t5_rst_fault", {31'b0, Fault}, 32'h0);
        chk("t5_rst_pc",    PC,             32'h0);
        Reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
